// File: rtl/timer_ctrl_pkg.sv
// Register map, control-bit positions and sequencer states for the interval-timer master.
package timer_ctrl_pkg;

    localparam logic [2:0] ADDR_STATUS  = 3'd0;
    localparam logic [2:0] ADDR_CONTROL = 3'd1;
    localparam logic [2:0] ADDR_PERL    = 3'd2;
    localparam logic [2:0] ADDR_PERH    = 3'd3;
    localparam logic [2:0] ADDR_SNAPL   = 3'd4;
    localparam logic [2:0] ADDR_SNAPH   = 3'd5;

    localparam int CTL_ITO   = 0;
    localparam int CTL_CONT  = 1;
    localparam int CTL_START = 2;
    localparam int CTL_STOP  = 3;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTL,
        ST_WR_STOP,
        ST_CLR,
        ST_SN_W,
        ST_SN_RL,
        ST_SN_RH,
        ST_SN_CAP
    } state_t;

endpackage

// File: rtl/timer_ctrl_master.sv
// Avalon-MM master sequencing start/stop/snapshot/IRQ-clear accesses to the interval timer.
// One event accepted per IDLE cycle (irq > stop > start > snap); anything arriving while busy is dropped.
module timer_ctrl_master
    import timer_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic        cmd_snap,
    input  logic [31:0] period_i,
    input  logic        cont_i,
    output logic        busy,
    output logic        tick,
    output logic [15:0] tick_count,
    output logic        snap_valid,
    output logic [31:0] snap_value,
    output logic [2:0]  av_address,
    output logic        av_chipselect,
    output logic        av_write_n,
    output logic [15:0] av_writedata,
    input  logic [15:0] av_readdata,
    input  logic        irq
);

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_av_chipselect;
    logic        r_av_write_n;
    logic [2:0]  r_av_address;
    logic [15:0] r_av_writedata;

    logic        w_cs_nxt;
    logic        w_wn_nxt;
    logic [2:0]  w_addr_nxt;
    logic [15:0] w_wdat_nxt;
    logic [15:0] w_ctl_start;
    logic [15:0] w_ctl_stop;

    logic [15:0] r_period_hi;
    logic        r_cont;
    logic [15:0] r_snap_lo;
    logic [31:0] r_snap_value;
    logic        r_snap_valid;
    logic        r_tick;
    logic [15:0] r_tick_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_ctl_start             = '0;
        w_ctl_start[CTL_ITO]    = 1'b1;
        w_ctl_start[CTL_CONT]   = r_cont;
        w_ctl_start[CTL_START]  = 1'b1;
        w_ctl_stop              = '0;
        w_ctl_stop[CTL_STOP]    = 1'b1;

        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (irq)            w_state_nxt = ST_CLR;
                else if (cmd_stop)  w_state_nxt = ST_WR_STOP;
                else if (cmd_start) w_state_nxt = ST_WR_PL;
                else if (cmd_snap)  w_state_nxt = ST_SN_W;
            end
            ST_WR_PL:  w_state_nxt = ST_WR_PH;
            ST_WR_PH:  w_state_nxt = ST_WR_CTL;
            ST_SN_W:   w_state_nxt = ST_SN_RL;
            ST_SN_RL:  w_state_nxt = ST_SN_RH;
            ST_SN_RH:  w_state_nxt = ST_SN_CAP;
            default:   w_state_nxt = ST_IDLE;
        endcase

        // Bus fields are decoded from the next state so they register alongside it.
        w_cs_nxt   = 1'b0;
        w_wn_nxt   = 1'b1;
        w_addr_nxt = r_av_address;
        w_wdat_nxt = r_av_writedata;
        case (w_state_nxt)
            ST_WR_PL: begin
                w_cs_nxt = 1'b1; w_wn_nxt = 1'b0;
                w_addr_nxt = ADDR_PERL; w_wdat_nxt = period_i[15:0];
            end
            ST_WR_PH: begin
                w_cs_nxt = 1'b1; w_wn_nxt = 1'b0;
                w_addr_nxt = ADDR_PERH; w_wdat_nxt = r_period_hi;
            end
            ST_WR_CTL: begin
                w_cs_nxt = 1'b1; w_wn_nxt = 1'b0;
                w_addr_nxt = ADDR_CONTROL; w_wdat_nxt = w_ctl_start;
            end
            ST_WR_STOP: begin
                w_cs_nxt = 1'b1; w_wn_nxt = 1'b0;
                w_addr_nxt = ADDR_CONTROL; w_wdat_nxt = w_ctl_stop;
            end
            ST_CLR: begin
                w_cs_nxt = 1'b1; w_wn_nxt = 1'b0;
                w_addr_nxt = ADDR_STATUS; w_wdat_nxt = 16'h0000;
            end
            ST_SN_W: begin
                w_cs_nxt = 1'b1; w_wn_nxt = 1'b0;
                w_addr_nxt = ADDR_SNAPL; w_wdat_nxt = 16'h0000;
            end
            ST_SN_RL: begin
                w_cs_nxt = 1'b1;
                w_addr_nxt = ADDR_SNAPL;
            end
            ST_SN_RH: begin
                w_cs_nxt = 1'b1;
                w_addr_nxt = ADDR_SNAPH;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_av_chipselect <= 1'b0;
            r_av_write_n    <= 1'b1;
            r_av_address    <= '0;
            r_av_writedata  <= '0;
            r_period_hi     <= '0;
            r_cont          <= 1'b0;
            r_snap_lo       <= '0;
            r_snap_value    <= '0;
            r_snap_valid    <= 1'b0;
            r_tick          <= 1'b0;
            r_tick_count    <= '0;
        end else begin
            r_av_chipselect <= w_cs_nxt;
            r_av_write_n    <= w_wn_nxt;
            r_av_address    <= w_addr_nxt;
            r_av_writedata  <= w_wdat_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_WR_PL) begin
                r_period_hi <= period_i[31:16];
                r_cont      <= cont_i;
            end
            r_tick <= (r_state == ST_CLR);
            if (r_state == ST_CLR) begin
                r_tick_count <= r_tick_count + 16'd1;
            end
            // readdata trails the address by one cycle: low half lands in SN_RH, high half in SN_CAP.
            if (r_state == ST_SN_RH) begin
                r_snap_lo <= av_readdata;
            end
            r_snap_valid <= (r_state == ST_SN_CAP);
            if (r_state == ST_SN_CAP) begin
                r_snap_value <= {av_readdata, r_snap_lo};
            end
        end
    end

    assign busy          = (r_state != ST_IDLE);
    assign tick          = r_tick;
    assign tick_count    = r_tick_count;
    assign snap_valid    = r_snap_valid;
    assign snap_value    = r_snap_value;
    assign av_address    = r_av_address;
    assign av_chipselect = r_av_chipselect;
    assign av_write_n    = r_av_write_n;
    assign av_writedata  = r_av_writedata;

endmodule

// File: tb/tb_timer_ctrl_master.sv
// Bench for timer_ctrl_master: directed scenarios plus a randomized run against a transaction-level model.
module tb_timer_ctrl_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_start = 1'b0;
    logic        cmd_stop = 1'b0;
    logic        cmd_snap = 1'b0;
    logic [31:0] period_i = '0;
    logic        cont_i = 1'b0;
    logic        busy;
    logic        tick;
    logic [15:0] tick_count;
    logic        snap_valid;
    logic [31:0] snap_value;
    logic [2:0]  av_address;
    logic        av_chipselect;
    logic        av_write_n;
    logic [15:0] av_writedata;
    logic [15:0] av_readdata = '0;
    logic        irq = 1'b0;

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int exp_tick = 0;

    logic [31:0] tm_counter = '0;
    logic [31:0] tm_snap = '0;

    timer_ctrl_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_start(cmd_start), .cmd_stop(cmd_stop), .cmd_snap(cmd_snap),
        .period_i(period_i), .cont_i(cont_i),
        .busy(busy), .tick(tick), .tick_count(tick_count),
        .snap_valid(snap_valid), .snap_value(snap_value),
        .av_address(av_address), .av_chipselect(av_chipselect),
        .av_write_n(av_write_n), .av_writedata(av_writedata),
        .av_readdata(av_readdata), .irq(irq)
    );

    always #5 clk = ~clk;

    // Timer slave model: snapshot on write to 4/5, registered read data one cycle after address.
    always @(posedge clk) begin
        if (av_chipselect && !av_write_n && (av_address == 3'd4 || av_address == 3'd5))
            tm_snap <= tm_counter;
        if (av_chipselect && av_write_n)
            av_readdata <= (av_address == 3'd5) ? tm_snap[31:16] :
                           (av_address == 3'd4) ? tm_snap[15:0] : 16'h0000;
    end

    always @(negedge clk) begin
        if (reset_n && av_chipselect && !av_write_n) wr_count <= wr_count + 1;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int w0;
        reset_n = 1'b0;
        repeat (3) cyc();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%0b exp=0", tick); end
        checks++; if (tick_count !== 16'h0) begin failures++; $display("FAIL reset_tick_count got=%h exp=0", tick_count); end
        checks++; if (snap_valid !== 1'b0) begin failures++; $display("FAIL reset_snap_valid got=%0b exp=0", snap_valid); end
        checks++; if (snap_value !== 32'h0) begin failures++; $display("FAIL reset_snap_value got=%h exp=0", snap_value); end
        checks++; if (av_chipselect !== 1'b0) begin failures++; $display("FAIL reset_cs got=%0b exp=0", av_chipselect); end
        checks++; if (av_write_n !== 1'b1) begin failures++; $display("FAIL reset_write_n got=%0b exp=1", av_write_n); end
        checks++; if (av_address !== 3'd0) begin failures++; $display("FAIL reset_addr got=%0d exp=0", av_address); end
        checks++; if (av_writedata !== 16'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0", av_writedata); end
        @(negedge clk) reset_n = 1'b1;
        w0 = wr_count;
        repeat (4) cyc();
        checks++; if (wr_count != w0 || av_chipselect !== 1'b0) begin failures++; $display("FAIL reset_idle_bus writes=%0d exp=0 cs=%0b", wr_count - w0, av_chipselect); end
        exp_tick = 0;
    endtask

    task automatic test_start();
        logic [2:0]  ea [3];
        logic [15:0] ed [3];
        ea[0] = 3'd2; ea[1] = 3'd3; ea[2] = 3'd1;
        ed[0] = 16'h86A0; ed[1] = 16'h0001; ed[2] = 16'h0007;
        period_i = 32'h0001_86A0; cont_i = 1'b1; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0; period_i = $urandom; cont_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (!(av_chipselect === 1'b1 && av_write_n === 1'b0 && av_address === ea[i] && av_writedata === ed[i] && busy === 1'b1)) begin
                failures++;
                $display("FAIL start_write%0d got cs=%0b wn=%0b a=%0d d=%h busy=%0b exp a=%0d d=%h", i, av_chipselect, av_write_n, av_address, av_writedata, busy, ea[i], ed[i]);
            end
            cyc();
        end
        checks++; if (busy !== 1'b0 || av_chipselect !== 1'b0) begin failures++; $display("FAIL start_done got busy=%0b cs=%0b exp 0 0", busy, av_chipselect); end
    endtask

    task automatic test_irq();
        irq = 1'b1;
        cyc();
        checks++;
        if (!(av_chipselect === 1'b1 && av_write_n === 1'b0 && av_address === 3'd0 && av_writedata === 16'h0 && tick === 1'b0)) begin
            failures++; $display("FAIL irq_clr got cs=%0b wn=%0b a=%0d d=%h tick=%0b exp write 0,0000", av_chipselect, av_write_n, av_address, av_writedata, tick);
        end
        irq = 1'b0;
        cyc();
        exp_tick = exp_tick + 1;
        checks++; if (tick !== 1'b1 || tick_count !== 16'(exp_tick)) begin failures++; $display("FAIL irq_tick got tick=%0b cnt=%h exp 1 %h", tick, tick_count, 16'(exp_tick)); end
        cyc();
        checks++; if (tick !== 1'b0 || av_chipselect !== 1'b0) begin failures++; $display("FAIL irq_single got tick=%0b cs=%0b exp 0 0", tick, av_chipselect); end
    endtask

    task automatic test_snap();
        tm_counter = 32'h0012_3456; cmd_snap = 1'b1;
        cyc();
        cmd_snap = 1'b0;
        checks++; if (!(av_chipselect === 1'b1 && av_write_n === 1'b0 && av_address === 3'd4)) begin failures++; $display("FAIL snap_w got cs=%0b wn=%0b a=%0d exp 1 0 4", av_chipselect, av_write_n, av_address); end
        cyc();
        tm_counter = 32'hDEAD_BEEF;
        checks++; if (!(av_chipselect === 1'b1 && av_write_n === 1'b1 && av_address === 3'd4)) begin failures++; $display("FAIL snap_rl got cs=%0b wn=%0b a=%0d exp 1 1 4", av_chipselect, av_write_n, av_address); end
        cyc();
        checks++; if (!(av_chipselect === 1'b1 && av_write_n === 1'b1 && av_address === 3'd5)) begin failures++; $display("FAIL snap_rh got cs=%0b wn=%0b a=%0d exp 1 1 5", av_chipselect, av_write_n, av_address); end
        cyc();
        checks++; if (!(av_chipselect === 1'b0 && busy === 1'b1 && snap_valid === 1'b0)) begin failures++; $display("FAIL snap_cap got cs=%0b busy=%0b sv=%0b exp 0 1 0", av_chipselect, busy, snap_valid); end
        cyc();
        checks++; if (!(snap_valid === 1'b1 && snap_value === 32'h0012_3456 && busy === 1'b0)) begin failures++; $display("FAIL snap_result got sv=%0b val=%h busy=%0b exp 1 00123456 0", snap_valid, snap_value, busy); end
        cyc();
        checks++; if (snap_valid !== 1'b0) begin failures++; $display("FAIL snap_pulse got sv=%0b exp 0", snap_valid); end
    endtask

    task automatic test_irq_vs_cmd();
        int w0;
        irq = 1'b1; cmd_start = 1'b1; period_i = $urandom;
        cyc();
        cmd_start = 1'b0;
        checks++; if (!(av_chipselect === 1'b1 && av_write_n === 1'b0 && av_address === 3'd0)) begin failures++; $display("FAIL irqcmd_clr_first got cs=%0b wn=%0b a=%0d exp write addr 0", av_chipselect, av_write_n, av_address); end
        irq = 1'b0;
        w0 = wr_count;
        repeat (5) cyc();
        exp_tick = exp_tick + 1;
        checks++; if (wr_count - w0 != 1) begin failures++; $display("FAIL irqcmd_dropped got writes=%0d exp 1", wr_count - w0); end
        checks++; if (tick_count !== 16'(exp_tick)) begin failures++; $display("FAIL irqcmd_count got %h exp %h", tick_count, 16'(exp_tick)); end
    endtask

    task automatic test_stop_busy();
        int w0;
        w0 = wr_count;
        period_i = 32'hABCD_1234; cont_i = 1'b0; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0; cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        checks++; if (av_address !== 3'd3 || av_writedata !== 16'hABCD) begin failures++; $display("FAIL stopbusy_ph got a=%0d d=%h exp 3 abcd", av_address, av_writedata); end
        cyc();
        checks++; if (av_address !== 3'd1 || av_writedata !== 16'h0005) begin failures++; $display("FAIL stopbusy_ctl got a=%0d d=%h exp 1 0005", av_address, av_writedata); end
        repeat (3) cyc();
        checks++; if (wr_count - w0 != 3 || busy !== 1'b0) begin failures++; $display("FAIL stopbusy_ignored got writes=%0d busy=%0b exp 3 0", wr_count - w0, busy); end
    endtask

    task automatic test_stop_idle();
        cmd_stop = 1'b1;
        cyc();
        cmd_stop = 1'b0;
        checks++; if (!(av_chipselect === 1'b1 && av_write_n === 1'b0 && av_address === 3'd1 && av_writedata === 16'h0008 && busy === 1'b1)) begin
            failures++; $display("FAIL stop_write got cs=%0b wn=%0b a=%0d d=%h busy=%0b exp write 1,0008", av_chipselect, av_write_n, av_address, av_writedata, busy);
        end
        cyc();
        checks++; if (busy !== 1'b0 || av_chipselect !== 1'b0) begin failures++; $display("FAIL stop_done got busy=%0b cs=%0b exp 0 0", busy, av_chipselect); end
    endtask

    task automatic test_random();
        int ref_busy, ref_ticks, got_ticks, n;
        logic [18:0] got_q[$];
        logic [18:0] exp_q[$];
        logic [31:0] snap_q[$];
        logic [31:0] es;
        reset_n = 1'b0; irq = 1'b0; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0;
        cyc();
        @(negedge clk) reset_n = 1'b1;
        cyc();
        ref_busy = 0; ref_ticks = 0; got_ticks = 0;
        for (int c = 0; c < 2008; c++) begin
            if (c < 2000) begin
                cmd_start = ($urandom_range(0, 5) == 0);
                cmd_stop  = ($urandom_range(0, 11) == 0);
                cmd_snap  = ($urandom_range(0, 5) == 0);
                period_i  = $urandom;
                cont_i    = 1'($urandom_range(0, 1));
                if (!irq && $urandom_range(0, 15) == 0) irq = 1'b1;
                if (ref_busy == 0) tm_counter = $urandom;
            end else begin
                cmd_start = 1'b0; cmd_stop = 1'b0; cmd_snap = 1'b0;
            end
            if (ref_busy > 0) begin
                ref_busy--;
            end else if (irq) begin
                exp_q.push_back({3'd0, 16'h0000}); ref_busy = 1; ref_ticks++;
            end else if (cmd_stop) begin
                exp_q.push_back({3'd1, 16'h0008}); ref_busy = 1;
            end else if (cmd_start) begin
                exp_q.push_back({3'd2, period_i[15:0]});
                exp_q.push_back({3'd3, period_i[31:16]});
                exp_q.push_back({3'd1, 16'h0005 | {14'd0, cont_i, 1'b0}});
                ref_busy = 3;
            end else if (cmd_snap) begin
                exp_q.push_back({3'd4, 16'h0000}); snap_q.push_back(tm_counter); ref_busy = 4;
            end
            cyc();
            if (tick === 1'b1) got_ticks++;
            if (av_chipselect === 1'b1 && av_write_n === 1'b0) begin
                got_q.push_back({av_address, av_writedata});
                if (av_address == 3'd0) irq = 1'b0;
            end
            if (snap_valid === 1'b1) begin
                checks++;
                if (snap_q.size() == 0) begin
                    failures++; $display("FAIL rand_snap_unexpected got val=%h exp no snapshot", snap_value);
                end else begin
                    es = snap_q.pop_front();
                    if (snap_value !== es) begin failures++; $display("FAIL rand_snap_value got %h exp %h", snap_value, es); end
                end
            end
        end
        checks++; if (got_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_write_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (got_q[i][18:16] !== exp_q[i][18:16] || (exp_q[i][18:16] != 3'd4 && got_q[i] !== exp_q[i])) begin
                failures++; $display("FAIL rand_write%0d got a=%0d d=%h exp a=%0d d=%h", i, got_q[i][18:16], got_q[i][15:0], exp_q[i][18:16], exp_q[i][15:0]);
            end
        end
        checks++; if (got_ticks != ref_ticks) begin failures++; $display("FAIL rand_tick_pulses got %0d exp %0d", got_ticks, ref_ticks); end
        checks++; if (tick_count !== 16'(ref_ticks)) begin failures++; $display("FAIL rand_tick_count got %h exp %h", tick_count, 16'(ref_ticks)); end
        checks++; if (snap_q.size() != 0) begin failures++; $display("FAIL rand_snap_missing got %0d outstanding exp 0", snap_q.size()); end
        exp_tick = ref_ticks;
    endtask

    task automatic test_wrap();
        force dut.r_tick_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_tick_count;
        irq = 1'b1;
        cyc();
        irq = 1'b0;
        cyc();
        checks++; if (tick !== 1'b1 || tick_count !== 16'h0000) begin failures++; $display("FAIL wrap got tick=%0b cnt=%h exp 1 0000", tick, tick_count); end
    endtask

    task automatic test_reset_mid();
        int w0;
        period_i = 32'h1111_2222; cmd_start = 1'b1;
        cyc();
        cmd_start = 1'b0;
        cyc();
        checks++; if (av_address !== 3'd3 || av_chipselect !== 1'b1) begin failures++; $display("FAIL rstmid_in_ph got a=%0d cs=%0b exp 3 1", av_address, av_chipselect); end
        reset_n = 1'b0;
        #1;
        checks++; if (av_chipselect !== 1'b0 || busy !== 1'b0 || av_write_n !== 1'b1) begin failures++; $display("FAIL rstmid_async got cs=%0b busy=%0b wn=%0b exp 0 0 1", av_chipselect, busy, av_write_n); end
        @(negedge clk) reset_n = 1'b1;
        w0 = wr_count;
        repeat (5) cyc();
        checks++; if (wr_count != w0 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_abandoned got writes=%0d busy=%0b exp 0 0", wr_count - w0, busy); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_irq();
        test_snap();
        test_irq_vs_cmd();
        test_stop_busy();
        test_stop_idle();
        test_random();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/timer_ctrl_master.md
# timer_ctrl_master

Avalon-MM initiator that drives the interval-timer peripheral (16-bit register map, 3-bit word address, registered readdata with 1-cycle latency, no waitrequest). It turns single-cycle commands into bus sequences: program the period and start, stop, and snapshot the counter. It also services the timer's level IRQ by clearing the timeout flag and emitting a tick. It sits between a local controller (or a soft-CPU replacement) and the timer slave port.

## Interface
- No parameters. Register addresses and control bits are fixed constants in the package.
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- cmd_start  in  1  pulse; program period_i, then start; accepted only in IDLE
- cmd_stop  in  1  pulse; stop timer; accepted only in IDLE
- cmd_snap  in  1  pulse; capture and read the 32-bit counter; accepted only in IDLE
- period_i  in  32  value written to the period registers, sampled with cmd_start
- cont_i  in  1  continuous-mode bit, sampled with cmd_start
- busy  out  1  high in every non-IDLE state
- tick  out  1  one-cycle pulse per serviced timeout
- tick_count  out  16  serviced-timeout counter; wraps 0xFFFF→0
- snap_valid  out  1  one-cycle pulse; snap_value updated
- snap_value  out  32  last captured counter value
- av_address  out  3  word address
- av_chipselect  out  1  bus select
- av_write_n  out  1  active-low write
- av_writedata  out  16  write data
- av_readdata  in  16  read data, valid the cycle after the address is presented
- irq  in  1  timer interrupt, level

## Operation
- Timer register map:
  - 0 = status: bit0 TO, bit1 RUN; any write clears TO.
  - 1 = control: bit0 ITO, bit1 CONT, bit2 START, bit3 STOP.
  - 2 = period low, 3 = period high.
  - 4 = snap low, 5 = snap high; a write to either captures the counter.
- All av_* outputs are registered and driven from the state register.
- A bus access is one cycle: chipselect=1, and write_n=0 for writes.
- In IDLE: chipselect=0, write_n=1; address and writedata hold their last values.
- IDLE priority, one event per cycle: irq > cmd_stop > cmd_start > cmd_snap. A command that loses arbitration or arrives while busy is dropped, not queued.
- Start sequence, latches period_i and cont_i:
  - WR_PL: addr 2, data period[15:0]
  - WR_PH: addr 3, data period[31:16]
  - WR_CTL: addr 1, data {12'b0, 1'b0, 1'b1, cont, 1'b1}
  - → IDLE
- Stop sequence: WR_STOP: addr 1, data 16'h0008 → IDLE. This clears ITO and CONT.
- IRQ service: CLR: addr 0 write, data 0. tick=1 and tick_count+1 in the following cycle. → IDLE.
- Snapshot sequence:
  - SN_W: addr 4 write
  - SN_RL: addr 4 read (chipselect=1, write_n=1)
  - SN_RH: addr 5 read; low half captured from av_readdata
  - SN_CAP: chipselect=0; high half captured
  - → IDLE; snap_value updated and snap_valid=1 in the IDLE cycle.
- States: IDLE, WR_PL, WR_PH, WR_CTL, WR_STOP, CLR, SN_W, SN_RL, SN_RH, SN_CAP. Every non-IDLE state lasts exactly one cycle.

## Timing
- Reset values:
  - state IDLE; av_chipselect 0; av_write_n 1; av_address 0; av_writedata 0.
  - busy 0; tick 0; tick_count 0; snap_valid 0; snap_value 0.
- Reset mid-sequence returns to IDLE immediately; the partial bus sequence is abandoned.
- cmd_start sampled at edge E0 → bus writes in cycles 1, 2, 3; busy 1 in cycles 1–3; IDLE in cycle 4.
- irq high in IDLE cycle 0 → CLR write in cycle 1. tick pulses in cycle 2, and tick_count shows the new value from cycle 2. irq is low by cycle 2, so there is no double service.
- Snapshot: cmd_snap at cycle 0 → snap_valid in cycle 5 (cycles 1–4 busy).
- irq arriving during a sequence is serviced on the first IDLE cycle after it. A timeout that coincides with the CLR write is lost; this is a known limitation and is not detected.
- A cmd_* pulse in the same cycle as irq is dropped.

## Structure
- Package timer_ctrl_pkg:
  - address constants ADDR_STATUS..ADDR_SNAPH
  - control bit indices CTL_ITO, CTL_CONT, CTL_START, CTL_STOP
  - state enum type
- Single module; no sub-module.

## Test plan
- Reset: all outputs at their reset values; no bus activity until the first command or irq.
- cmd_start with period_i=32'h0001_86A0, cont_i=1 → writes (2,86A0), (3,0001), (1,0007) in consecutive cycles; busy=1 for 3 cycles.
- Timer model asserts irq → one write to addr 0, data 0; tick pulse; tick_count 0→1. Preload 0xFFFF: next service → tick_count 0.
- cmd_snap with model counter 32'h0012_3456 → write addr 4, read 4, read 5; snap_value=32'h0012_3456; snap_valid one cycle, 5 cycles after cmd.
- irq and cmd_start asserted in the same cycle → CLR first, cmd_start dropped. cmd_stop while busy → ignored. cmd_stop in IDLE → write (1,0008).
- reset_n low during WR_PH → av_chipselect 0 immediately; after release, state is IDLE and no further writes occur.
